// File: rtl/banco_registros.sv
// banco_registros: MIPS general-purpose register file.
// 32 x 32-bit entries, two combinational read ports, one synchronous write port.
// Entry 0 always reads zero. A write can be forwarded to a read port in the same cycle.
module banco_registros #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [ADDR_WIDTH-1:0] rAddr1,
    input  logic [ADDR_WIDTH-1:0] rAddr2,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic                  regWriteFlag,
    output logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] data2
);

    // Storage; testbenches may reach this array hierarchically, so the name and range are fixed.
    logic [DATA_WIDTH-1:0] registerBank [0:NUM_REGS-1];

    // A write to entry 0 is dropped, so entry 0 stays zero in the array too.
    logic writeEn;
    assign writeEn = regWriteFlag && (wAddr != '0);

    // Async reset wipes all entries; otherwise write-back lands on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                registerBank[i] <= '0;
            end
        end else if (writeEn) begin
            registerBank[wAddr] <= wrData;
        end
    end

    // Read port 1: reset and address 0 force zero; a matching write is forwarded.
    always_comb begin
        data1 = '0;
        if (!rst && (rAddr1 != '0)) begin
            if (writeEn && (wAddr == rAddr1)) begin
                data1 = wrData;
            end else begin
                data1 = registerBank[rAddr1];
            end
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        data2 = '0;
        if (!rst && (rAddr2 != '0)) begin
            if (writeEn && (wAddr == rAddr2)) begin
                data2 = wrData;
            end else begin
                data2 = registerBank[rAddr2];
            end
        end
    end

endmodule

// File: tb/tb_banco_registros.sv
// tb_banco_registros: scoreboard bench for the register file.
// Stimulus drives one read/write per cycle and queues the expected read data from a
// plain array model; a monitor pops and compares at each falling edge.
module tb_banco_registros;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wrData;
    logic [4:0]  rAddr1;
    logic [4:0]  rAddr2;
    logic [4:0]  wAddr;
    logic        regWriteFlag;
    logic [31:0] data1;
    logic [31:0] data2;

    banco_registros dut (
        .clk          (clk),
        .rst          (rst),
        .wrData       (wrData),
        .rAddr1       (rAddr1),
        .rAddr2       (rAddr2),
        .wAddr        (wAddr),
        .regWriteFlag (regWriteFlag),
        .data1        (data1),
        .data2        (data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } expT;

    expT         expQ[$];
    logic [31:0] model [0:31];
    int          checks = 0;
    int          errors = 0;

    // Expected read of one port from the architectural rules.
    function automatic logic [31:0] refRead(input logic r, input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd, input logic [4:0] ra);
        if (r || ra == 5'd0) return 32'h0;
        if (we && wa != 5'd0 && wa == ra) return wd;
        return model[ra];
    endfunction

    // Drive one cycle, queue its expected read data, then commit the write to the model.
    task automatic cycle(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                         input string nm);
        expT e;
        rst = r;
        regWriteFlag = we;
        wAddr = wa;
        wrData = wd;
        rAddr1 = a1;
        rAddr2 = a2;
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end
        e.name = nm;
        e.exp1 = refRead(r, we, wa, wd, a1);
        e.exp2 = refRead(r, we, wa, wd, a2);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (!r && we && wa != 5'd0) model[wa] = wd;
    endtask

    // Monitor: read ports are combinational, so every cycle presents a result.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            checks++;
            if (data1 !== e.exp1 || data2 !== e.exp2) begin
                errors++;
                $display("FAIL %s data1=%h data2=%h expected data1=%h data2=%h",
                         e.name, data1, data2, e.exp1, e.exp2);
            end
        end
    end

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        regWriteFlag = 1'b0;
        wAddr = '0;
        wrData = '0;
        rAddr1 = '0;
        rAddr2 = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clk);
        #1;
        // Reset state: everything reads zero while reset is held.
        cycle(1'b1, 1'b1, 5'd3, 32'h1111_1111, 5'd3, 5'd31, "reset_hold");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd31, "after_reset");

        // Preload entry k = k*0x01010101 through the write port, then sweep both ports.
        for (int k = 0; k < 32; k++) begin
            v = 32'h0101_0101 * k;
            cycle(1'b0, 1'b1, 5'(k), v, 5'd0, 5'd0, "preload");
        end
        for (int k = 0; k < 32; k++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k), "sweep");
        end

        // Directed cases.
        cycle(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, "write5");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "read5_both");
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "write0_bypass");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd31, "read0");
        cycle(1'b0, 1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd7, "we_off_during");
        cycle(1'b0, 1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd6, "we_off_after");
        cycle(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd8, 5'd9, "bypass2");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "held9");
        cycle(1'b0, 1'b1, 5'd31, 32'hA5A5_5A5A, 5'd31, 5'd31, "bypass_both");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd30, "read31");

        // Mid-run reset between edges: reads drop to zero at once, write blocked.
        cycle(1'b1, 1'b1, 5'd5, 32'h7777_7777, 5'd5, 5'd9, "rst_midrun");
        for (int k = 0; k < 32; k++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(k), 5'(k), "post_rst_sweep");
        end

        // Randomised traffic with a bias toward bypass hits and rare resets.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa, a1, a2;
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), wa, $urandom(),
                  a1, a2, "random");
        end

        rst = 1'b0;
        regWriteFlag = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
